// File: rtl/zmips_rf_pkg.sv
// -----------------------------------------------------------------------------
// zmips_rf_pkg
// Shared definitions for the zmips_regfile_sb register file:
//   - default DATA_W / ADDR_W
//   - PC slot offsets counted back from the top of the address space
//     (latched PC at NREG-PC_LATCHED_OFS, live PC at NREG-PC_LIVE_OFS)
//   - address-class enum and decode function used by each read port
// -----------------------------------------------------------------------------
package zmips_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // PC_LATCHED_IDX = NREG - PC_LATCHED_OFS, PC_LIVE_IDX = NREG - PC_LIVE_OFS
  localparam int PC_LATCHED_OFS = 2;
  localparam int PC_LIVE_OFS    = 1;

  // Encoding doubles as the select of the 4:1 read mux.
  typedef enum logic [1:0] {
    AC_STORAGE    = 2'd0,
    AC_PC_LATCHED = 2'd1,
    AC_PC_LIVE    = 2'd2,
    AC_UNMAPPED   = 2'd3
  } addr_class_e;

  function automatic addr_class_e addr_class(input logic [31:0] addr,
                                             input int          addr_w,
                                             input int          ngpr);
    logic [31:0] nreg;
    logic [31:0] ngpr_u;
    nreg   = 32'd1 << addr_w;
    ngpr_u = ngpr;
    if (addr < ngpr_u)                          return AC_STORAGE;
    else if (addr == nreg - 32'(PC_LATCHED_OFS)) return AC_PC_LATCHED;
    else if (addr == nreg - 32'(PC_LIVE_OFS))    return AC_PC_LIVE;
    return AC_UNMAPPED;
  endfunction

endpackage

// File: rtl/zmips_regfile_sb_if.sv
// -----------------------------------------------------------------------------
// zmips_regfile_sb_if
// Bus between decode/execute and the register file.
//   master (pipeline side) drives: rd_addr_0/1, wr_en/wr_addr/wr_data,
//          iss_en/iss_addr, pc_val, pc_wr
//   slave  (register file) drives: rd_data_0/1, rd_busy_0/1, busy_cnt
// -----------------------------------------------------------------------------
interface zmips_regfile_sb_if
  import zmips_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr_0;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [DATA_W-1:0] rd_data_0;
  logic [DATA_W-1:0] rd_data_1;
  logic              rd_busy_0;
  logic              rd_busy_1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] pc_val;
  logic              pc_wr;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rd_addr_0, rd_addr_1, wr_en, wr_addr, wr_data,
           iss_en, iss_addr, pc_val, pc_wr,
    input  rd_data_0, rd_data_1, rd_busy_0, rd_busy_1, busy_cnt
  );

  modport slave (
    input  rd_addr_0, rd_addr_1, wr_en, wr_addr, wr_data,
           iss_en, iss_addr, pc_val, pc_wr,
    output rd_data_0, rd_data_1, rd_busy_0, rd_busy_1, busy_cnt
  );
endinterface

// File: rtl/zmips_mux432.sv
// -----------------------------------------------------------------------------
// zmips_mux432
// 4:1 multiplexer, 32 bits wide.
//   i_sel        : select (0..3)
//   i_d0..i_d3   : data inputs
//   o_y          : selected data
// -----------------------------------------------------------------------------
module zmips_mux432 (
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  input  logic [31:0] i_d3,
  output logic [31:0] o_y
);
  always_comb begin
    unique case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end
endmodule

// File: rtl/zmips_rf_rdport.sv
// -----------------------------------------------------------------------------
// zmips_rf_rdport
// One combinational read port: classifies the address, selects storage /
// latched PC / live PC / zero, and produces the busy flag.
// Optional feature: define ZMIPS_RF_BYPASS_EN to forward a same-cycle
// writeback to the read data (and suppress busy unless re-issued).
//   i_addr              : read address
//   i_regs, i_busy      : storage array and scoreboard bits
//   i_pc_reg, i_pc_val  : latched and live PC
//   i_wr_*, i_iss_*     : same-cycle writeback / issue (used by bypass)
//   o_data, o_busy      : read data and pending-write flag
// -----------------------------------------------------------------------------
module zmips_rf_rdport
  import zmips_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NGPR   = 30
) (
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [NGPR-1:0][DATA_W-1:0]  i_regs,
  input  logic [NGPR-1:0]              i_busy,
  input  logic [DATA_W-1:0]            i_pc_reg,
  input  logic [DATA_W-1:0]            i_pc_val,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_iss_en,
  input  logic [ADDR_W-1:0]            i_iss_addr,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_busy
);
  localparam int IDX_W = (NGPR > 1) ? $clog2(NGPR) : 1;

  addr_class_e       w_class;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_store_data;
  logic              w_store_busy;

  assign w_class = addr_class(32'(i_addr), ADDR_W, NGPR);
  assign w_idx   = i_addr[IDX_W-1:0];

`ifdef ZMIPS_RF_BYPASS_EN
  logic w_hit;
  // Storage class already guarantees the address is < NGPR.
  assign w_hit        = i_wr_en && (i_wr_addr == i_addr) && (w_class == AC_STORAGE);
  assign w_store_data = w_hit ? i_wr_data : i_regs[w_idx];
  // The forwarded write retires the reservation unless it is re-issued now.
  assign w_store_busy = w_hit ? (i_iss_en && (i_iss_addr == i_addr)) : i_busy[w_idx];
`else
  logic w_unused_bypass;
  assign w_store_data    = i_regs[w_idx];
  assign w_store_busy    = i_busy[w_idx];
  assign w_unused_bypass = ^{i_wr_en, i_wr_addr, i_wr_data, i_iss_en, i_iss_addr};
`endif

  assign o_busy = (w_class == AC_STORAGE) && w_store_busy;

  generate
    if (DATA_W == 32) begin : g_mux32
      zmips_mux432 u_mux (
        .i_sel (w_class),
        .i_d0  (w_store_data),
        .i_d1  (i_pc_reg),
        .i_d2  (i_pc_val),
        .i_d3  (32'd0),
        .o_y   (o_data)
      );
    end else begin : g_mux_n
      always_comb begin
        unique case (w_class)
          AC_STORAGE:    o_data = w_store_data;
          AC_PC_LATCHED: o_data = i_pc_reg;
          AC_PC_LIVE:    o_data = i_pc_val;
          default:       o_data = '0;
        endcase
      end
    end
  endgenerate
endmodule

// File: rtl/zmips_regfile_sb.sv
// -----------------------------------------------------------------------------
// zmips_regfile_sb
// 2R/1W integer register file with a per-register busy scoreboard and the two
// top addresses mapped to the PC (NREG-2 latched, NREG-1 live).
// Optional feature: ZMIPS_RF_BYPASS_EN enables write-through read forwarding.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous reset, active high; beats every write/issue/capture
//   bus  : zmips_regfile_sb_if.slave (reads, writeback, issue, PC, busy_cnt)
// NGPR must satisfy NGPR <= 2**ADDR_W - 2.
// -----------------------------------------------------------------------------
module zmips_regfile_sb
  import zmips_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NGPR   = 30
) (
  input  logic               clk,
  input  logic               rst,
  zmips_regfile_sb_if.slave  bus
);
  localparam int                IDX_W  = (NGPR > 1) ? $clog2(NGPR) : 1;
  localparam logic [ADDR_W-1:0] NGPR_A = ADDR_W'(NGPR);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  logic [NGPR-1:0][DATA_W-1:0] r_regs;
  logic [NGPR-1:0]             r_busy;
  logic [DATA_W-1:0]           r_pc;
  logic [ADDR_W:0]             r_busy_cnt;

  logic                        w_wr_ok;
  logic                        w_iss_ok;
  logic [IDX_W-1:0]            w_wr_idx;
  logic [IDX_W-1:0]            w_iss_idx;
  logic [NGPR-1:0]             w_busy_nxt;
  logic                        w_cnt_inc;
  logic                        w_cnt_dec;

  // Writes and issues outside the storage range (incl. the PC slots) are dropped.
  assign w_wr_ok   = bus.wr_en  && (bus.wr_addr  < NGPR_A);
  assign w_iss_ok  = bus.iss_en && (bus.iss_addr < NGPR_A);
  assign w_wr_idx  = bus.wr_addr[IDX_W-1:0];
  assign w_iss_idx = bus.iss_addr[IDX_W-1:0];

  always_comb begin
    // NOTE: start from the current value so every bit is assigned on every
    // path; a missing default here would infer a latch.
    w_busy_nxt = r_busy;
    // NOTE: blocking assignments in combinational logic, ordered so the set
    // overrides a clear to the same register (new reservation outstanding).
    if (w_wr_ok)  w_busy_nxt[w_wr_idx]  = 1'b0;
    if (w_iss_ok) w_busy_nxt[w_iss_idx] = 1'b1;
  end

  // Counter tracks the real 0->1 and 1->0 transitions, so it equals popcount.
  assign w_cnt_inc = w_iss_ok && !r_busy[w_iss_idx];
  assign w_cnt_dec = w_wr_ok && r_busy[w_wr_idx] &&
                     !(w_iss_ok && (w_iss_idx == w_wr_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset explicitly because software may read
      // registers before writing them; this keeps it in flops, not RAM.
      r_regs     <= '0;
      r_busy     <= '0;
      r_pc       <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_ok)    r_regs[w_wr_idx] <= bus.wr_data;
      if (bus.pc_wr)  r_pc             <= bus.pc_val;
      r_busy <= w_busy_nxt;
      unique case ({w_cnt_inc, w_cnt_dec})
        2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
        2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
        default: r_busy_cnt <= r_busy_cnt;
      endcase
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

  zmips_rf_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NGPR(NGPR)) u_rdport_0 (
    .i_addr     (bus.rd_addr_0),
    .i_regs     (r_regs),
    .i_busy     (r_busy),
    .i_pc_reg   (r_pc),
    .i_pc_val   (bus.pc_val),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .o_data     (bus.rd_data_0),
    .o_busy     (bus.rd_busy_0)
  );

  zmips_rf_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NGPR(NGPR)) u_rdport_1 (
    .i_addr     (bus.rd_addr_1),
    .i_regs     (r_regs),
    .i_busy     (r_busy),
    .i_pc_reg   (r_pc),
    .i_pc_val   (bus.pc_val),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .o_data     (bus.rd_data_1),
    .o_busy     (bus.rd_busy_1)
  );
endmodule

// File: tb/tb_zmips_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_zmips_regfile_sb
// Scenario tasks build a step table (stimulus, expected outputs). Each step's
// expectation is pushed to a scoreboard queue as the stimulus is driven and
// popped and compared at the following falling edge. Expectations follow the
// ZMIPS_RF_BYPASS_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_zmips_regfile_sb;

`ifdef ZMIPS_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zmips_regfile_sb_if bus ();

  zmips_regfile_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        pc_wr;
    logic [31:0] pc_val;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
  } stim_t;

  typedef struct packed {
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [5:0]  cnt;
  } obs_t;

  obs_t  sb_q[$];
  string sb_name[$];
  stim_t st_q[$];
  obs_t  ex_q[$];
  bit    ck_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic stim_t st(input int r, input int we, input int wa,
                               input logic [31:0] wd, input int ie, input int ia,
                               input int pw, input logic [31:0] pv,
                               input int a0, input int a1);
    stim_t s;
    s.rst = r[0];   s.wr_en = we[0];    s.wr_addr = wa[4:0]; s.wr_data = wd;
    s.iss_en = ie[0]; s.iss_addr = ia[4:0]; s.pc_wr = pw[0]; s.pc_val = pv;
    s.ra0 = a0[4:0]; s.ra1 = a1[4:0];
    return s;
  endfunction

  function automatic obs_t ob(input logic [31:0] d0, input int b0,
                              input logic [31:0] d1, input int b1, input int cnt);
    obs_t o;
    o.d0 = d0; o.b0 = b0[0]; o.d1 = d1; o.b1 = b1[0]; o.cnt = cnt[5:0];
    return o;
  endfunction

  function automatic obs_t sample();
    return {bus.rd_data_0, bus.rd_busy_0, bus.rd_data_1, bus.rd_busy_1, bus.busy_cnt};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("d0=%h b0=%b d1=%h b1=%b cnt=%0d", o.d0, o.b0, o.d1, o.b1, o.cnt);
  endfunction

  task automatic clear_steps();
    st_q.delete(); ex_q.delete(); ck_q.delete();
  endtask

  task automatic add(input stim_t s, input bit c, input obs_t e);
    st_q.push_back(s); ck_q.push_back(c); ex_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    rst          = s.rst;
    bus.wr_en    = s.wr_en;
    bus.wr_addr  = s.wr_addr;
    bus.wr_data  = s.wr_data;
    bus.iss_en   = s.iss_en;
    bus.iss_addr = s.iss_addr;
    bus.pc_wr    = s.pc_wr;
    bus.pc_val   = s.pc_val;
    bus.rd_addr_0 = s.ra0;
    bus.rd_addr_1 = s.ra1;
  endtask

  // Drive step i just after the rising edge, queue its expectation, then
  // wait for the falling edge where the outputs are settled.
  task automatic apply(input string tag, input int i);
    @(posedge clk); #1;
    drive(st_q[i]);
    if (ck_q[i]) begin
      sb_q.push_back(ex_q[i]);
      sb_name.push_back($sformatf("%s[%0d]", tag, i));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t got, exp; string nm;
    clear_steps();
    add(st(1,0,0,0,0,0,0,0,0,0), 0, '0);
    add(st(0,0,0,0,0,0,0,0,5,30), 1, ob(0,0,0,0,0));
    add(st(0,0,0,0,0,0,0,32'h1234,31,29), 1, ob(32'h1234,0,0,0,0));
    for (int i = 0; i < st_q.size(); i++) begin
      apply("reset", i);
      if (ck_q[i]) begin
        got = sample(); exp = sb_q.pop_front(); nm = sb_name.pop_front(); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  task automatic test_write();
    obs_t got, exp; string nm;
    clear_steps();
    add(st(0,1,5,32'hDEADBEEF,0,0,0,0,5,6), 1, ob(BYP ? 32'hDEADBEEF : 32'h0,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,5,6), 1, ob(32'hDEADBEEF,0,0,0,0));
    add(st(0,1,0,32'h0000A5A5,0,0,0,0,5,0), 0, '0);
    add(st(0,1,29,32'h29292929,0,0,0,0,0,29), 1,
        ob(32'h0000A5A5,0, BYP ? 32'h29292929 : 32'h0,0,0));
    add(st(0,0,0,0,0,0,0,0,29,0), 1, ob(32'h29292929,0,32'h0000A5A5,0,0));
    for (int i = 0; i < st_q.size(); i++) begin
      apply("write", i);
      if (ck_q[i]) begin
        got = sample(); exp = sb_q.pop_front(); nm = sb_name.pop_front(); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  task automatic test_pc();
    obs_t got, exp; string nm;
    clear_steps();
    add(st(0,0,0,0,0,0,1,32'h00400010,30,31), 1, ob(0,0,32'h00400010,0,0));
    add(st(0,0,0,0,0,0,0,32'h00400014,30,31), 1, ob(32'h00400010,0,32'h00400014,0,0));
    add(st(0,1,30,32'hFFFFFFFF,0,0,0,32'h00400014,30,31), 1,
        ob(32'h00400010,0,32'h00400014,0,0));
    add(st(0,1,31,32'hFFFFFFFF,0,0,0,32'h00400018,30,31), 1,
        ob(32'h00400010,0,32'h00400018,0,0));
    add(st(0,0,0,0,0,0,0,0,30,5), 1, ob(32'h00400010,0,32'hDEADBEEF,0,0));
    for (int i = 0; i < st_q.size(); i++) begin
      apply("pc", i);
      if (ck_q[i]) begin
        got = sample(); exp = sb_q.pop_front(); nm = sb_name.pop_front(); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    obs_t got, exp; string nm;
    clear_steps();
    add(st(0,0,0,0,1,7,0,0,7,8), 1, ob(0,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,7,8), 1, ob(0,1,0,0,1));
    add(st(0,1,7,32'h77,1,7,0,0,7,8), 1, ob(BYP ? 32'h77 : 32'h0,1,0,0,1));
    add(st(0,0,0,0,0,0,0,0,7,8), 1, ob(32'h77,1,0,0,1));
    add(st(0,1,7,32'h78,0,0,0,0,7,8), 1, ob(BYP ? 32'h78 : 32'h77, BYP ? 0 : 1,0,0,1));
    add(st(0,0,0,0,0,0,0,0,7,8), 1, ob(32'h78,0,0,0,0));
    add(st(0,0,0,0,1,7,0,0,7,8), 1, ob(32'h78,0,0,0,0));
    add(st(0,0,0,0,1,7,0,0,7,8), 1, ob(32'h78,1,0,0,1));
    add(st(0,0,0,0,0,0,0,0,7,8), 1, ob(32'h78,1,0,0,1));
    add(st(0,1,7,32'h79,0,0,0,0,7,8), 1, ob(BYP ? 32'h79 : 32'h78, BYP ? 0 : 1,0,0,1));
    add(st(0,0,0,0,0,0,0,0,7,8), 1, ob(32'h79,0,0,0,0));
    add(st(0,0,0,0,1,2,0,0,2,4), 1, ob(0,0,0,0,0));
    add(st(0,1,2,32'h22,1,4,0,0,2,4), 1, ob(BYP ? 32'h22 : 32'h0, BYP ? 0 : 1,0,0,1));
    add(st(0,0,0,0,0,0,0,0,2,4), 1, ob(32'h22,0,0,1,1));
    add(st(0,0,0,0,1,30,0,0,30,4), 1, ob(32'h00400010,0,0,1,1));
    add(st(0,0,0,0,0,0,0,0,30,4), 1, ob(32'h00400010,0,0,1,1));
    for (int i = 0; i < st_q.size(); i++) begin
      apply("sb", i);
      if (ck_q[i]) begin
        got = sample(); exp = sb_q.pop_front(); nm = sb_name.pop_front(); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  // r4 is still reserved on entry; filling r1..r29 and r0 reaches NGPR=30.
  task automatic test_fill_and_reset();
    obs_t got, exp; string nm;
    clear_steps();
    for (int a = 1; a <= 30; a++) add(st(0,0,0,0,1,a % 30,0,0,0,29), 0, '0);
    add(st(0,0,0,0,1,31,0,0,0,29), 1, ob(32'h0000A5A5,1,32'h29292929,1,30));
    add(st(0,1,3,32'h33,1,31,0,0,3,31), 1, ob(BYP ? 32'h33 : 32'h0, BYP ? 0 : 1,0,0,30));
    add(st(0,0,0,0,0,0,0,0,3,30), 1, ob(32'h33,0,32'h00400010,0,29));
    add(st(1,1,5,32'hAAAA,1,4,1,32'h123,5,3), 0, '0);
    add(st(0,0,0,0,0,0,0,0,5,30), 1, ob(0,0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,7,0), 1, ob(0,0,0,0,0));
    for (int i = 0; i < st_q.size(); i++) begin
      apply("fill", i);
      if (ck_q[i]) begin
        got = sample(); exp = sb_q.pop_front(); nm = sb_name.pop_front(); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  task automatic test_bypass();
    obs_t got, exp; string nm;
    clear_steps();
    add(st(0,1,9,32'h11111111,0,0,0,0,9,10), 1, ob(BYP ? 32'h11111111 : 32'h0,0,0,0,0));
    add(st(0,1,9,32'h12345678,0,0,0,0,9,9), 1,
        ob(BYP ? 32'h12345678 : 32'h11111111,0, BYP ? 32'h12345678 : 32'h11111111,0,0));
    add(st(0,0,0,0,0,0,0,0,9,9), 1, ob(32'h12345678,0,32'h12345678,0,0));
    add(st(0,1,9,32'hABCD0001,1,9,0,0,9,10), 1,
        ob(BYP ? 32'hABCD0001 : 32'h12345678, BYP ? 1 : 0,0,0,0));
    add(st(0,0,0,0,0,0,0,0,9,10), 1, ob(32'hABCD0001,1,0,0,1));
    add(st(0,1,9,32'h5,0,0,0,0,9,10), 1, ob(BYP ? 32'h5 : 32'hABCD0001, BYP ? 0 : 1,0,0,1));
    add(st(0,0,0,0,0,0,0,0,9,10), 1, ob(32'h5,0,0,0,0));
    for (int i = 0; i < st_q.size(); i++) begin
      apply("bypass", i);
      if (ck_q[i]) begin
        got = sample(); exp = sb_q.pop_front(); nm = sb_name.pop_front(); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  task automatic test_reset_hold();
    obs_t got, exp; string nm;
    clear_steps();
    add(st(1,1,9,32'hFFFF,1,9,1,32'hCAFE,8,30), 0, '0);
    add(st(1,1,9,32'hFFFF,1,9,1,32'hCAFE,8,30), 1, ob(0,0,0,0,0));
    add(st(1,1,9,32'hFFFF,1,9,1,32'hCAFE,8,30), 1, ob(0,0,0,0,0));
    add(st(0,0,0,0,0,0,0,32'h55,9,31), 1, ob(0,0,32'h55,0,0));
    add(st(0,0,0,0,0,0,0,0,9,30), 1, ob(0,0,0,0,0));
    for (int i = 0; i < st_q.size(); i++) begin
      apply("rsthold", i);
      if (ck_q[i]) begin
        got = sample(); exp = sb_q.pop_front(); nm = sb_name.pop_front(); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  initial begin
    drive(st(1,0,0,0,0,0,0,0,0,0));
    test_reset();
    test_write();
    test_pc();
    test_scoreboard();
    test_fill_and_reset();
    test_bypass();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zmips_regfile_sb.md
Name: zmips_regfile_sb

Overview:
Parametrised successor to the 2R/1W integer register file, with synchronous reset, a per-register busy scoreboard for long-latency writebacks, and the two top addresses mapped to the PC. Sits in decode: the read ports feed operand latches, and the busy flags drive the decode stall logic. Writeback and PC-capture ports come from the execute/memory stages.

Parameters:
DATA_W, 32, register and PC width in bits
ADDR_W, 5, register address width; NREG = 2**ADDR_W
NGPR, 30, number of storage registers (addresses 0..NGPR-1); must satisfy NGPR <= NREG-2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
rd_addr_0  in  ADDR_W  read port 0 address
rd_addr_1  in  ADDR_W  read port 1 address
rd_data_0  out  DATA_W  read port 0 data (combinational)
rd_data_1  out  DATA_W  read port 1 data (combinational)
rd_busy_0  out  1  rd_addr_0 has a write pending
rd_busy_1  out  1  rd_addr_1 has a write pending
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
iss_en  in  1  mark iss_addr busy (long-latency op issued)
iss_addr  in  ADDR_W  destination being reserved
pc_val  in  DATA_W  live PC
pc_wr  in  1  capture pc_val into pc_reg
busy_cnt  out  ADDR_W+1  number of busy registers

Behaviour:
- Address map: 0..NGPR-1 = storage; NREG-2 = pc_reg (latched PC); NREG-1 = pc_val (live, combinational); NGPR..NREG-3, if any, read 0.
- Reset (rst=1 at edge): all storage regs, pc_reg, busy bits and busy_cnt go to 0. Reset has priority over every write, issue and capture in the same cycle. Pending scoreboard entries are discarded.
- Write: at the edge, if wr_en and wr_addr < NGPR, then regfile[wr_addr] <= wr_data. Writes to any other address are ignored, including the PC addresses.
- Read latency: zero. Reads are combinational from the current array state.
- Without bypass, a read of the address being written in the same cycle returns the old value.
- pc_reg <= pc_val at the edge when pc_wr is 1.
- Scoreboard: busy[a] is set at the edge by iss_en with iss_addr=a, and cleared by wr_en with wr_addr=a.
  - Set and clear on the same address in the same cycle: set wins (the new reservation is outstanding).
  - Issue to an address >= NGPR is ignored.
  - Issue to an already-busy register leaves it busy; busy_cnt is unchanged.
- rd_busy_n = busy[rd_addr_n] for storage addresses; it is 0 for the PC and unmapped addresses.
- busy_cnt is registered and always equals popcount(busy). Per cycle it changes by -1, 0 or +1, computed from the actual set/clear transitions.
  - Maximum value NGPR; never wraps.
- Plain writes (wr_en without a prior issue) are legal and leave busy at 0.

Optional Feature:
Macro ZMIPS_RF_BYPASS_EN enables write-through forwarding.
- Defined: if wr_en and wr_addr == rd_addr_n < NGPR, then rd_data_n = wr_data. In that case rd_busy_n reads 0 unless iss_en targets the same address in the same cycle.
- Undefined: reads return the array contents; rd_busy_n reflects the registered busy bit only.

Decomposition:
- Package zmips_rf_pkg holds:
  - localparams for the PC_LATCHED_IDX and PC_LIVE_IDX offsets (NREG-2, NREG-1)
  - the default DATA_W and ADDR_W
  - the address-class decode function (storage/pc_latched/pc_live/unmapped)
- One sub-module, zmips_rf_rdport, instantiated twice. It performs the address-class decode, the 4:1 output mux (reusing zmips_mux432 for the 32-bit case) and the bypass/busy logic for one read port.

Test Plan:
- Reset then write r5=0xDEADBEEF; next cycle rd_addr_0=5 -> rd_data_0=0xDEADBEEF, rd_busy_0=0, busy_cnt=0.
- pc_wr with pc_val=0x00400010, then pc_val=0x00400014; rd_addr_0=30, rd_addr_1=31 -> 0x00400010 and 0x00400014. A write to address 30 leaves pc_reg unchanged.
- iss_en on r7 -> busy_cnt=1, rd_busy=1. wr_en to r7 with iss_en to r7 in the same cycle -> busy stays 1, busy_cnt=1. A later lone wr_en -> busy 0, busy_cnt=0.
- Issue r1..r29 plus r0 -> busy_cnt=30. Issue r31 -> ignored, busy_cnt stays 30. Assert rst mid-stream with wr_en=1 -> all regs 0 and busy_cnt=0 the next cycle.
- Same-cycle write r9=0x12345678 and read r9:
  - with ZMIPS_RF_BYPASS_EN -> 0x12345678
  - without it -> previous value; the new value is visible the next cycle.
- With rst held, apply wr_en, iss_en and pc_wr together -> all state remains 0.
